// File: rtl/conv_sa_pe_gen.sv
// conv_sa_pe_gen: systolic PE packing NPACK weight lanes against one shared activation.
// Optional macro CONV_SA_PE_SAT_EN: saturating psum narrowing plus per-lane out_sat flags.
module conv_sa_pe_gen #(
  parameter int DW     = 8,
  parameter int NPACK  = 2,
  parameter int ACC_W  = 24,
  parameter int PSUM_W = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPACK*DW-1:0]     in_w,
  input  logic [DW-1:0]           in_x,
  input  logic                    in_mode,
  input  logic [NPACK*PSUM_W-1:0] in_psum,
  input  logic                    in_en,
  input  logic                    in_rst,
  input  logic                    in_flush,
  output logic [NPACK*DW-1:0]     out_w,
  output logic [DW-1:0]           out_x,
  output logic                    out_mode,
  output logic [NPACK*PSUM_W-1:0] out_psum,
  output logic                    out_en,
  output logic                    out_rst,
  output logic                    out_flush
`ifdef CONV_SA_PE_SAT_EN
  ,
  output logic [NPACK-1:0]        out_sat
`endif
);

  logic [NPACK-1:0][2*DW-1:0]   prod_s;
  logic [NPACK-1:0][2*DW-1:0]   prod_r;
  logic                         mode2_r;
  logic [NPACK-1:0][ACC_W-1:0]  acc_r;
  logic [NPACK-1:0][PSUM_W-1:0] narrow_s;

  // Operands get one extra bit so a single signed multiplier covers both modes
  function automatic logic [2*DW-1:0] lane_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic sgn);
    logic signed [2*DW+1:0] a_e;
    logic signed [2*DW+1:0] b_e;
    logic signed [2*DW+1:0] p;
    a_e = (2*DW+2)'($signed({sgn & a[DW-1], a}));
    b_e = (2*DW+2)'($signed({sgn & b[DW-1], b}));
    p   = a_e * b_e;
    return p[2*DW-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] prod_ext(input logic [2*DW-1:0] p, input logic sgn);
    logic [ACC_W-1:0] r;
    if (sgn) r = ACC_W'($signed(p));
    else     r = ACC_W'(p);
    return r;
  endfunction

`ifdef CONV_SA_PE_SAT_EN
  localparam logic [ACC_W-1:0] UMAX_C = ACC_W'({PSUM_W{1'b1}});
  localparam logic [ACC_W-1:0] SMAX_C = ACC_W'({(PSUM_W-1){1'b1}});
  localparam logic [ACC_W-1:0] SMIN_C = ~SMAX_C;

  logic                         acc_mode_r;
  logic [NPACK-1:0]             sat_s;

  // Returns {clamped, value}; the lane's range follows the last accumulated mode
  function automatic logic [PSUM_W:0] narrow(input logic [ACC_W-1:0] a, input logic sgn);
    logic [PSUM_W:0] r;
    if (sgn) begin
      if ($signed(a) > $signed(SMAX_C))      r = {1'b1, SMAX_C[PSUM_W-1:0]};
      else if ($signed(a) < $signed(SMIN_C)) r = {1'b1, SMIN_C[PSUM_W-1:0]};
      else                                   r = {1'b0, a[PSUM_W-1:0]};
    end else begin
      if (a > UMAX_C) r = {1'b1, UMAX_C[PSUM_W-1:0]};
      else            r = {1'b0, a[PSUM_W-1:0]};
    end
    return r;
  endfunction
`endif

  // Per-lane products from stage-1 registers and narrowed accumulator views
  always_comb begin
    prod_s   = '0;
    narrow_s = '0;
`ifdef CONV_SA_PE_SAT_EN
    sat_s    = '0;
`endif
    for (int k = 0; k < NPACK; k++) begin
      prod_s[k] = lane_mul(out_w[k*DW +: DW], out_x, out_mode);
`ifdef CONV_SA_PE_SAT_EN
      {sat_s[k], narrow_s[k]} = narrow(acc_r[k], acc_mode_r);
`else
      narrow_s[k] = acc_r[k][PSUM_W-1:0];
`endif
    end
  end

  // Stage 1 pass-through registers and stage 2 product registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_w     <= '0;
      out_x     <= '0;
      out_mode  <= 1'b0;
      out_en    <= 1'b0;
      out_rst   <= 1'b0;
      out_flush <= 1'b0;
      prod_r    <= '0;
      mode2_r   <= 1'b0;
    end else begin
      out_w     <= in_w;
      out_x     <= in_x;
      out_mode  <= in_mode;
      out_en    <= in_en;
      out_rst   <= in_rst;
      out_flush <= in_flush;
      prod_r    <= prod_s;
      mode2_r   <= out_mode;
    end
  end

  // Stage 3: accumulate, save-and-clear into the psum chain, or shift the chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= '0;
      out_psum <= '0;
`ifdef CONV_SA_PE_SAT_EN
      acc_mode_r <= 1'b0;
      out_sat    <= '0;
`endif
    end else begin
      for (int k = 0; k < NPACK; k++) begin
        if (in_rst) begin
          out_psum[k*PSUM_W +: PSUM_W] <= narrow_s[k];
          acc_r[k]                     <= '0;
        end else begin
          if (in_en) acc_r[k] <= acc_r[k] + prod_ext(prod_r[k], mode2_r);
          else       acc_r[k] <= acc_r[k];
          if (in_flush) out_psum[k*PSUM_W +: PSUM_W] <= in_psum[k*PSUM_W +: PSUM_W];
          else          out_psum[k*PSUM_W +: PSUM_W] <= out_psum[k*PSUM_W +: PSUM_W];
        end
      end
`ifdef CONV_SA_PE_SAT_EN
      if (in_rst) begin
        out_sat    <= sat_s;
        acc_mode_r <= acc_mode_r;
      end else if (in_en) begin
        out_sat    <= out_sat;
        acc_mode_r <= mode2_r;
      end else begin
        out_sat    <= out_sat;
        acc_mode_r <= acc_mode_r;
      end
`endif
    end
  end

endmodule

// File: tb/tb_conv_sa_pe_gen.sv
// Scoreboard bench for conv_sa_pe_gen (NPACK=2): a behavioural model pushes expected psum
// values as stimulus is issued; a negedge monitor pops them on every save or flush shift.
module tb_conv_sa_pe_gen;
  localparam int DW = 8, NPACK = 2, ACC_W = 24, PSUM_W = 19;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [NPACK*DW-1:0]     in_w = '0;
  logic [DW-1:0]           in_x = '0;
  logic                    in_mode = 1'b0;
  logic [NPACK*PSUM_W-1:0] in_psum = '0;
  logic                    in_en = 1'b0, in_rst = 1'b0, in_flush = 1'b0;
  logic [NPACK*DW-1:0]     out_w;
  logic [DW-1:0]           out_x;
  logic                    out_mode;
  logic [NPACK*PSUM_W-1:0] out_psum;
  logic                    out_en, out_rst, out_flush;
`ifdef CONV_SA_PE_SAT_EN
  logic [NPACK-1:0]        out_sat;
  logic [NPACK-1:0]        sat_q[$];
  logic [NPACK-1:0]        exp_sat;
  logic                    m_mode = 1'b0;
`endif

  conv_sa_pe_gen #(.DW(DW), .NPACK(NPACK), .ACC_W(ACC_W), .PSUM_W(PSUM_W)) dut (
    .clk(clk), .rst(rst), .in_w(in_w), .in_x(in_x), .in_mode(in_mode), .in_psum(in_psum),
    .in_en(in_en), .in_rst(in_rst), .in_flush(in_flush), .out_w(out_w), .out_x(out_x),
    .out_mode(out_mode), .out_psum(out_psum), .out_en(out_en), .out_rst(out_rst),
    .out_flush(out_flush)
`ifdef CONV_SA_PE_SAT_EN
    , .out_sat(out_sat)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_on  = 1'b0;
  logic [NPACK*PSUM_W-1:0] exp_q[$];
  logic [NPACK*PSUM_W-1:0] exp_v;

  typedef struct packed {
    logic                    en;
    logic                    rs;
    logic                    fl;
    logic [NPACK*PSUM_W-1:0] ps;
  } flags_t;
  flags_t pipe0 = '0, pipe1 = '0;
  logic [ACC_W-1:0] m_acc0 = '0, m_acc1 = '0;

  function automatic logic [ACC_W-1:0] m_prod(input logic [7:0] x, input logic [7:0] w,
                                               input logic m);
    int p;
    if (m) p = int'($signed(x)) * int'($signed(w));
    else   p = int'(x) * int'(w);
    return p[ACC_W-1:0];
  endfunction

`ifdef CONV_SA_PE_SAT_EN
  function automatic logic [PSUM_W:0] m_narrow(input logic [ACC_W-1:0] a, input logic m);
    int v;
    logic s;
    s = 1'b0;
    if (m) v = int'($signed(a));
    else   v = int'(a);
    if (m && v > 262143)       begin v = 262143;  s = 1'b1; end
    else if (m && v < -262144) begin v = -262144; s = 1'b1; end
    else if (!m && v > 524287) begin v = 524287;  s = 1'b1; end
    return {s, v[PSUM_W-1:0]};
  endfunction
`endif

  // Data is driven now; its control flags are driven two steps later, as the array does
  task automatic step(input logic [7:0] x, input logic [7:0] w0, input logic [7:0] w1,
                      input logic m, input logic en, input logic rs, input logic fl,
                      input logic [NPACK*PSUM_W-1:0] ps);
`ifdef CONV_SA_PE_SAT_EN
    logic [PSUM_W:0] n0, n1;
`endif
    in_x     = x;
    in_w     = {w1, w0};
    in_mode  = m;
    in_en    = pipe1.en;
    in_rst   = pipe1.rs;
    in_flush = pipe1.fl;
    in_psum  = pipe1.ps;
    pipe1    = pipe0;
    pipe0    = {en, rs, fl, ps};
    if (rs) begin
`ifdef CONV_SA_PE_SAT_EN
      n0 = m_narrow(m_acc0, m_mode);
      n1 = m_narrow(m_acc1, m_mode);
      exp_q.push_back({n1[PSUM_W-1:0], n0[PSUM_W-1:0]});
      sat_q.push_back({n1[PSUM_W], n0[PSUM_W]});
`else
      exp_q.push_back({m_acc1[PSUM_W-1:0], m_acc0[PSUM_W-1:0]});
`endif
      m_acc0 = '0;
      m_acc1 = '0;
    end else begin
      if (en) begin
        m_acc0 = m_acc0 + m_prod(x, w0, m);
        m_acc1 = m_acc1 + m_prod(x, w1, m);
`ifdef CONV_SA_PE_SAT_EN
        m_mode = m;
`endif
      end
      if (fl) exp_q.push_back(ps);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    repeat (3) step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Scoreboard monitor: each save or flush shift must match the oldest expected psum
  always @(negedge clk) begin
    if (mon_on && !rst && (out_rst || out_flush)) begin
      n_tests = n_tests + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL psum_unexpected: out_psum=%h appeared with no expected entry", out_psum);
      end else begin
        exp_v = exp_q.pop_front();
        if (out_psum !== exp_v) begin
          n_fail = n_fail + 1;
          $display("FAIL psum: got %h expected %h (t=%0t)", out_psum, exp_v, $time);
        end
      end
`ifdef CONV_SA_PE_SAT_EN
      if (out_rst && sat_q.size() != 0) begin
        exp_sat = sat_q.pop_front();
        n_tests = n_tests + 1;
        if (out_sat !== exp_sat) begin
          n_fail = n_fail + 1;
          $display("FAIL out_sat: got %b expected %b", out_sat, exp_sat);
        end
      end
`endif
    end
  end

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    n_tests = n_tests + 1;
    if ({out_w, out_x, out_mode, out_psum, out_en, out_rst, out_flush} !== '0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_state: got w=%h x=%h psum=%h expected all zero", out_w, out_x, out_psum);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_passthrough;
    in_w = 16'hA55A; in_x = 8'hC3; in_mode = 1'b1;
    in_en = 1'b1; in_rst = 1'b1; in_flush = 1'b1;
    @(posedge clk);
    #1;
    n_tests = n_tests + 1;
    if ({out_w, out_x, out_mode, out_en, out_rst, out_flush} !== {16'hA55A, 8'hC3, 4'b1111}) begin
      n_fail = n_fail + 1;
      $display("FAIL passthru_1: got %h/%h/%b%b%b%b expected a55a/c3/1111",
               out_w, out_x, out_mode, out_en, out_rst, out_flush);
    end
    in_w = 16'h1234; in_x = 8'h0F; in_mode = 1'b0;
    in_en = 1'b0; in_rst = 1'b0; in_flush = 1'b0;
    #2;
    n_tests = n_tests + 1;
    if ({out_w, out_x, out_en} !== {16'hA55A, 8'hC3, 1'b1}) begin
      n_fail = n_fail + 1;
      $display("FAIL passthru_hold: got %h/%h/%b expected a55a/c3/1", out_w, out_x, out_en);
    end
    @(posedge clk);
    #1;
    n_tests = n_tests + 1;
    if ({out_w, out_x, out_mode, out_en, out_rst, out_flush} !== {16'h1234, 8'h0F, 4'b0000}) begin
      n_fail = n_fail + 1;
      $display("FAIL passthru_2: got %h/%h/%b expected 1234/0f/0", out_w, out_x, out_mode);
    end
  endtask

  task automatic test_reset_mid_accum;
    pipe0 = '0; pipe1 = '0;
    repeat (3) step(8'd10, 8'd3, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (2) step(8'd7, 8'd9, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    in_x = '0; in_w = '0; in_mode = 1'b0; in_en = 1'b0; in_rst = 1'b0; in_flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests = n_tests + 1;
    if ({out_w, out_x, out_mode, out_psum, out_en, out_rst, out_flush} !== '0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_mid: got w=%h x=%h psum=%h en=%b expected all zero",
               out_w, out_x, out_psum, out_en);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    pipe0 = '0; pipe1 = '0; m_acc0 = '0; m_acc1 = '0;
    exp_q.delete();
    mon_on = 1'b1;
    step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    drain();
  endtask

  task automatic test_unsigned;
    repeat (4) step(8'd255, 8'd255, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    drain();
  endtask

  task automatic test_signed;
    repeat (2) step(8'h80, 8'h7F, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    drain();
  endtask

  task automatic test_stall;
    step(8'd1,  8'd2,  8'd3,  1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(8'd4,  8'd5,  8'd6,  1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(8'd7,  8'd8,  8'd9,  1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(8'd10, 8'd11, 8'd12, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(8'd13, 8'd14, 8'd15, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(8'd20, 8'd20, 8'd20, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    step(8'd0,  8'd0,  8'd0,  1'b0, 1'b0, 1'b1, 1'b0, '0);
    drain();
  endtask

  task automatic test_flush;
    repeat (2) step(8'd3, 8'd5, 8'd7, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    repeat (3) step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, {19'h00011, 19'h00011});
    step(8'd6, 8'd2, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, {19'h00022, 19'h00022});
    drain();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      step(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
           ($urandom_range(3, 0) != 0), ($urandom_range(7, 0) == 0),
           ($urandom_range(7, 0) == 0), (NPACK*PSUM_W)'({$urandom(), $urandom()}));
    end
    step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    drain();
  endtask

`ifdef CONV_SA_PE_SAT_EN
  task automatic test_sat;
    repeat (12) step(8'd200, 8'd250, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    repeat (24) step(8'h9C, 8'd125, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_reset_mid_accum();
    test_unsigned();
    test_signed();
    test_stall();
    test_flush();
    test_back_to_back();
`ifdef CONV_SA_PE_SAT_EN
    test_sat();
`endif
    n_tests = n_tests + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_drain: %0d expected entries never produced, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_sa_pe_gen.md
Name: conv_sa_pe_gen

Overview:
Parametrised processing element for the conv systolic array; successor to the fixed dual-uint8 PE. Packs NPACK weight lanes against one shared activation per cycle. Supports a runtime signed/unsigned mode, an accumulate-enable (stall) input, and wider internal accumulators with configurable output narrowing. Chains weights and activations horizontally and shifts partial sums vertically (flush) exactly like the current array tiles.

Parameters:
DW, 8, weight/activation element width (bits)
NPACK, 2, weight lanes per PE (1..4); lane k uses in_w[k*DW +: DW]
ACC_W, 24, per-lane internal accumulator width (>= 2*DW)
PSUM_W, 19, per-lane partial-sum width on the flush chain (<= ACC_W)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_w  in  NPACK*DW  packed weight lanes from left PE
in_x  in  DW  activation from upper/left PE
in_mode  in  1  0: unsigned x unsigned; 1: signed x signed (travels with data)
in_psum  in  NPACK*PSUM_W  partial sums from upper PE (flush chain)
in_en  in  1  accumulate enable, accumulator-stage aligned
in_rst  in  1  save-and-clear, accumulator-stage aligned
in_flush  in  1  shift-register mode for psum chain
out_w  out  NPACK*DW  in_w delayed 1 cycle
out_x  out  DW  in_x delayed 1 cycle
out_mode  out  1  in_mode delayed 1 cycle
out_psum  out  NPACK*PSUM_W  psum chain register
out_en, out_rst, out_flush  out  1 each  flags delayed 1 cycle

Behaviour:
- Reset: every register (pipeline, accumulators, psum chain, all out_*) clears to 0 asynchronously; no pending product survives reset; first accumulation after deassert starts from 0.
- Pipeline: stage1 registers in_w/in_x/in_mode; stage2 registers NPACK products (2*DW bits each, signedness per mode); stage3 is accumulator. Product of data presented at cycle t reaches accumulator at cycle t+2; flags (in_en, in_rst, in_flush) sampled at stage3 refer to that product. Controller delays flags by 2 cycles.
- Accumulate: each lane acc_k <= acc_k + sext/zext(prod_k) to ACC_W, sign-extended if the product's mode was 1. Wraps modulo 2^ACC_W. in_en=0: acc holds.
- in_rst=1 (highest priority): psum_k <= narrow(acc_k); acc_k <= 0; current stage3 product discarded regardless of in_en.
- else in_flush=1: psum_k <= in_psum lane k. Else psum holds.
- in_rst and in_flush same cycle: rst wins for psum; flush ignored that cycle.
- narrow(): low PSUM_W bits of acc (truncation) unless the optional feature is enabled.
- Mode may change on any cycle; each product uses the mode captured with its own data.
- Pass-through outputs: exactly 1-cycle latency, independent of en/rst/flush.

Optional Feature:
CONV_SA_PE_SAT_EN: narrow() clamps: mode-1 lanes to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1], mode-0 lanes to [0, 2^PSUM_W-1], using the mode of the last accumulated product. Adds output out_sat [NPACK], set per lane on in_rst if that lane clamped, held until next in_rst, 0 on reset. Without the macro: truncation, no out_sat port.

Test Plan:
- Reset mid-accumulation: accumulate 3 products, assert rst -> all outputs 0; next rst-save yields psum 0 for only-zero inputs.
- Unsigned, NPACK=2: x=255,w0=255,w1=1 for 4 enabled cycles then in_rst -> psum0=260100, psum1=1020 (truncated: psum0=260100 mod 2^19=260100).
- Signed: mode=1, x=-128,w0=127,w1=-128, 2 cycles -> psum0=-32512 (two's complement 19b), psum1=32768.
- Stall: 5 products with in_en low on cycles 2 and 4 -> sum of products 1,3,5 only; in_rst same cycle as a product discards it.
- Flush: in_rst then 3 cycles in_flush with in_psum=0x00011 per lane -> out_psum shows saved value then 0x00011 after 1 cycle; rst+flush together -> saved value.
- SAT_EN: unsigned acc 600000 with PSUM_W=19 -> psum=524287, out_sat=1; signed -300000 -> -262144, out_sat=1.
